// File: rtl/alu_pkg.sv
// Shared ALU definitions: group selects (ALUFun[5:4]), full function codes, default width.
// Imported by the interface, the shifter and the alu_core top.
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  localparam logic [1:0] GRP_ARITH = 2'b00;
  localparam logic [1:0] GRP_LOGIC = 2'b01;
  localparam logic [1:0] GRP_SHIFT = 2'b10;
  localparam logic [1:0] GRP_CMP   = 2'b11;

  localparam logic [5:0] ALU_ADD = 6'b000000;
  localparam logic [5:0] ALU_SUB = 6'b000001;
  localparam logic [5:0] ALU_AND = 6'b011000;
  localparam logic [5:0] ALU_OR  = 6'b011110;
  localparam logic [5:0] ALU_XOR = 6'b010110;
  localparam logic [5:0] ALU_NOR = 6'b010001;
  localparam logic [5:0] ALU_A   = 6'b011010;
  localparam logic [5:0] ALU_SLL = 6'b100000;
  localparam logic [5:0] ALU_SRL = 6'b100001;
  localparam logic [5:0] ALU_SRA = 6'b100011;
  localparam logic [5:0] ALU_EQ  = 6'b110011;
  localparam logic [5:0] ALU_NEQ = 6'b110001;
  localparam logic [5:0] ALU_LT  = 6'b110101;
  localparam logic [5:0] ALU_LEZ = 6'b111101;
  localparam logic [5:0] ALU_LTZ = 6'b111011;
  localparam logic [5:0] ALU_GTZ = 6'b111111;

endpackage

// File: rtl/alu_core_if.sv
// Operand/function bundle into alu_core and registered result/flags back out.
// master = issuing datapath, slave = the ALU.
interface alu_core_if #(parameter int WIDTH = alu_pkg::ALU_WIDTH);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [5:0]       ALUFun;
  logic             Sign;
  logic [WIDTH-1:0] Z;
  logic             Zero;
  logic             Overflow;
  logic             Negative;

  modport master (
    output A, B, ALUFun, Sign,
    input  Z, Zero, Overflow, Negative
  );

  modport slave (
    input  A, B, ALUFun, Sign,
    output Z, Zero, Overflow, Negative
  );

endinterface

// File: rtl/alu_shifter.sv
// Purpose: log2(WIDTH)-stage barrel shifter for SLL/SRL/SRA.
// Latency: combinational.
// Backpressure: none.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] din,
  input  logic [SHW-1:0]   sh,
  input  logic             left,
  input  logic             arith,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [0:SHW];
  logic             fill;

  assign fill     = arith & din[WIDTH-1];
  assign stage[0] = din;

  // Stage i shifts by 2**i when sh[i] is set.
  for (genvar i = 0; i < SHW; i++) begin : g_stage
    localparam int D = 1 << i;
    assign stage[i+1] = !sh[i] ? stage[i] :
                        left   ? {stage[i][WIDTH-1-D:0], {D{1'b0}}} :
                                 {{D{fill}}, stage[i][WIDTH-1:D]};
  end

  assign dout = stage[SHW];

endmodule

// File: rtl/alu_core.sv
// Purpose: MIPS-style ALU (add/sub, logic, shift, compare); flag registers built only with ALU_FLAGS_EN.
// Latency: one cycle, result and flags registered.
// Backpressure: none, accepts a new operation every cycle.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input logic      clk,
  input logic      rst_n,
  alu_core_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  logic             op_sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] res;
  logic             carry;
  logic             ovf;
  logic             neg;
  logic             cmp_flag;
  logic [WIDTH-1:0] sh_out;
  logic [WIDTH-1:0] z_nxt;
  logic [WIDTH-1:0] z_q;

  // Single adder: adds only for ADD, subtracts (A + ~B + 1) for every other op.
  assign op_sub = (bus.ALUFun != ALU_ADD);
  assign b_eff  = op_sub ? ~bus.B : bus.B;
  assign sum    = {1'b0, bus.A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op_sub};
  assign res    = sum[WIDTH-1:0];
  assign carry  = sum[WIDTH];

  assign ovf = bus.Sign ? ((bus.A[WIDTH-1] == b_eff[WIDTH-1]) && (res[WIDTH-1] != bus.A[WIDTH-1]))
                        : (op_sub ? ~carry : carry);
  assign neg = bus.Sign ? (res[WIDTH-1] ^ ovf) : (op_sub & ~carry);

  alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .din   (bus.B),
    .sh    (bus.A[SHW-1:0]),
    .left  (~bus.ALUFun[0]),
    .arith (bus.ALUFun[1]),
    .dout  (sh_out)
  );

  always_comb begin
    cmp_flag = 1'b0;
    case (bus.ALUFun)
      ALU_EQ:  cmp_flag = (bus.A == bus.B);
      ALU_NEQ: cmp_flag = (bus.A != bus.B);
      ALU_LT:  cmp_flag = neg;
      ALU_LEZ: cmp_flag = bus.A[WIDTH-1] | (bus.A == '0);
      ALU_LTZ: cmp_flag = bus.A[WIDTH-1];
      ALU_GTZ: cmp_flag = ~bus.A[WIDTH-1] & (bus.A != '0);
      default: cmp_flag = 1'b0;
    endcase
  end

  // Codes not listed within a group fall through to zero.
  always_comb begin
    z_nxt = '0;
    case (bus.ALUFun[5:4])
      GRP_ARITH: if (bus.ALUFun == ALU_ADD || bus.ALUFun == ALU_SUB) z_nxt = res;
      GRP_LOGIC: begin
        case (bus.ALUFun)
          ALU_AND: z_nxt = bus.A & bus.B;
          ALU_OR:  z_nxt = bus.A | bus.B;
          ALU_XOR: z_nxt = bus.A ^ bus.B;
          ALU_NOR: z_nxt = ~(bus.A | bus.B);
          ALU_A:   z_nxt = bus.A;
          default: z_nxt = '0;
        endcase
      end
      GRP_SHIFT: begin
        if (bus.ALUFun == ALU_SLL || bus.ALUFun == ALU_SRL || bus.ALUFun == ALU_SRA)
          z_nxt = sh_out;
      end
      GRP_CMP:   z_nxt = {{(WIDTH-1){1'b0}}, cmp_flag};
      default:   z_nxt = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) z_q <= '0;
    else        z_q <= z_nxt;
  end

  assign bus.Z = z_q;

`ifdef ALU_FLAGS_EN
  logic zero_q;
  logic ovf_q;
  logic neg_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
      neg_q  <= 1'b0;
    end else begin
      zero_q <= (res == '0);
      ovf_q  <= ovf;
      neg_q  <= neg;
    end
  end

  assign bus.Zero     = zero_q;
  assign bus.Overflow = ovf_q;
  assign bus.Negative = neg_q;
`else
  assign bus.Zero     = 1'b0;
  assign bus.Overflow = 1'b0;
  assign bus.Negative = 1'b0;
`endif

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed plan vectors, randomized ops against an
// arithmetic reference model, back-to-back pipelining and reset behaviour.
module tb_alu_core;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  alu_core_if #(.WIDTH(32)) bus ();

  alu_core #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_FLAGS_EN
  localparam logic [2:0] FMASK = 3'b111;
`else
  localparam logic [2:0] FMASK = 3'b000;
`endif

  logic [5:0] ops [16] = '{6'b000000, 6'b000001, 6'b011000, 6'b011110, 6'b010110, 6'b010001,
                           6'b011010, 6'b100000, 6'b100001, 6'b100011, 6'b110011, 6'b110001,
                           6'b110101, 6'b111101, 6'b111011, 6'b111111};

  // Reference: exact integer arithmetic, then wrap / range-check. Returns {Z, Zero, Overflow, Negative}.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic [5:0] f, input logic s);
    longint     ua, ub, sa, sb, r;
    logic [31:0] z, bs;
    logic [4:0]  sh;
    logic        zf, of, nf, is_add, lt;
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    is_add = (f == 6'b000000);
    if (s) begin
      r  = is_add ? sa + sb : sa - sb;
      of = (r > 64'sd2147483647) || (r < -64'sd2147483648);
      nf = (r < 0);
      lt = (sa < sb);
    end else begin
      r  = is_add ? ua + ub : ua - ub;
      of = is_add ? (r > 64'sd4294967295) : (ua < ub);
      nf = !is_add && (ua < ub);
      lt = (ua < ub);
    end
    zf = (r[31:0] == 32'h0);
    sh = a[4:0];
    bs = b;
    case (f)
      6'b000000, 6'b000001: z = r[31:0];
      6'b011000: z = a & b;
      6'b011110: z = a | b;
      6'b010110: z = a ^ b;
      6'b010001: z = ~(a | b);
      6'b011010: z = a;
      6'b100000: z = bs << sh;
      6'b100001: z = bs >> sh;
      6'b100011: z = $signed(bs) >>> sh;
      6'b110011: z = {31'h0, a == b};
      6'b110001: z = {31'h0, a != b};
      6'b110101: z = {31'h0, lt};
      6'b111101: z = {31'h0, $signed(a) <= 0};
      6'b111011: z = {31'h0, $signed(a) < 0};
      6'b111111: z = {31'h0, $signed(a) > 0};
      default:   z = 32'h0;
    endcase
    return {z, {zf, of, nf} & FMASK};
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'($urandom_range(0, 40));
      default: return 32'($urandom);
    endcase
  endfunction

  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] f, input logic s);
    @(negedge clk);
    bus.A = a; bus.B = b; bus.ALUFun = f; bus.Sign = s;
  endtask

  task automatic test_reset();
    logic [35:0] obs, exp;
    rst_n = 1'b0;
    drive(32'h1, 32'hFFFF_FFFF, 6'b000000, 1'b0);
    repeat (2) @(posedge clk);
    #1 obs = {bus.Z, bus.Zero, bus.Overflow, bus.Negative};
    n_cmp++;
    if (obs !== 36'h0) begin
      n_err++; $display("FAIL reset_hold: got %h expected %h", obs, 36'h0);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1 obs = {bus.Z, bus.Zero, bus.Overflow, bus.Negative};
    exp = {32'h0, 3'b110 & FMASK};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL reset_first_load: got %h expected %h", obs, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  f;
    logic        s;
    logic [31:0] z;
    logic [2:0]  fl;
  } vec_t;

  // Expected values written out by hand: {Zero, Overflow, Negative}.
  vec_t dir [12] = '{
    '{32'h1,        32'hFFFF_FFFF, 6'b000000, 1'b0, 32'h0,         3'b110},
    '{32'h1,        32'hFFFF_FFFF, 6'b011000, 1'b0, 32'h1,         3'b011},
    '{32'h1,        32'hFFFF_FFFF, 6'b100000, 1'b0, 32'hFFFF_FFFE, 3'b011},
    '{32'h1,        32'hFFFF_FFFF, 6'b110011, 1'b0, 32'h0,         3'b011},
    '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 6'b110101, 1'b0, 32'h1,        3'b011},
    '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 6'b110101, 1'b1, 32'h1,        3'b001},
    '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 6'b000001, 1'b1, 32'hFFFF_FFFF, 3'b001},
    '{32'h7FFF_FFFF, 32'h1,        6'b000000, 1'b1, 32'h8000_0000, 3'b010},
    '{32'd31,       32'h8000_0000, 6'b100001, 1'b0, 32'h1,         3'b011},
    '{32'd31,       32'h8000_0000, 6'b100011, 1'b0, 32'hFFFF_FFFF, 3'b011},
    '{32'h20,       32'h8000_0000, 6'b100000, 1'b0, 32'h8000_0000, 3'b011},
    '{32'h5,        32'h5,         6'b001111, 1'b0, 32'h0,         3'b100}
  };

  task automatic test_directed();
    logic [35:0] obs, exp;
    for (int i = 0; i < 12; i++) begin
      drive(dir[i].a, dir[i].b, dir[i].f, dir[i].s);
      @(posedge clk);
      #1 obs = {bus.Z, bus.Zero, bus.Overflow, bus.Negative};
      exp = {dir[i].z, dir[i].fl & FMASK};
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL directed[%0d] f=%b: got %h expected %h", i, dir[i].f, obs, exp);
      end
    end
  endtask

  task automatic test_random();
    logic [35:0] obs, exp;
    logic [31:0] a, b;
    logic [5:0]  f;
    logic        s;
    for (int i = 0; i < 400; i++) begin
      a = rnd_operand();
      b = ($urandom_range(0, 7) == 0) ? a : rnd_operand();
      f = ($urandom_range(0, 15) == 0) ? 6'($urandom) : ops[$urandom_range(0, 15)];
      s = 1'($urandom);
      drive(a, b, f, s);
      @(posedge clk);
      #1 obs = {bus.Z, bus.Zero, bus.Overflow, bus.Negative};
      exp = model(a, b, f, s);
      n_cmp++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL random[%0d] a=%h b=%h f=%b s=%b: got %h expected %h", i, a, b, f, s, obs, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [35:0] obs, exp, prev;
    logic [31:0] a, b;
    logic [5:0]  f;
    logic        s;
    prev = {bus.Z, bus.Zero, bus.Overflow, bus.Negative};
    for (int i = 0; i < 32; i++) begin
      a = rnd_operand(); b = rnd_operand(); f = ops[i % 16]; s = 1'(i / 16);
      @(negedge clk);
      bus.A = a; bus.B = b; bus.ALUFun = f; bus.Sign = s;
      #1 obs = {bus.Z, bus.Zero, bus.Overflow, bus.Negative};
      n_cmp++;
      if (obs !== prev) begin
        n_err++; $display("FAIL b2b_hold[%0d]: got %h expected %h", i, obs, prev);
      end
      @(posedge clk);
      #1 obs = {bus.Z, bus.Zero, bus.Overflow, bus.Negative};
      exp = model(a, b, f, s);
      n_cmp++;
      if (obs !== exp) begin
        n_err++; $display("FAIL b2b[%0d] f=%b: got %h expected %h", i, f, obs, exp);
      end
      prev = exp;
    end
  endtask

  task automatic test_midreset();
    logic [35:0] obs, exp;
    drive(32'h7FFF_FFFF, 32'h1, 6'b000000, 1'b1);
    @(posedge clk);
    @(negedge clk);
    bus.A = 32'h3; bus.B = 32'h4; bus.ALUFun = 6'b000000; bus.Sign = 1'b0;
    #2 rst_n = 1'b0;
    #1 obs = {bus.Z, bus.Zero, bus.Overflow, bus.Negative};
    n_cmp++;
    if (obs !== 36'h0) begin
      n_err++; $display("FAIL midreset_async: got %h expected %h", obs, 36'h0);
    end
    @(posedge clk);
    #1 obs = {bus.Z, bus.Zero, bus.Overflow, bus.Negative};
    n_cmp++;
    if (obs !== 36'h0) begin
      n_err++; $display("FAIL midreset_discard: got %h expected %h", obs, 36'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.A = 32'h2; bus.B = 32'h3; bus.ALUFun = 6'b000000; bus.Sign = 1'b0;
    @(posedge clk);
    #1 obs = {bus.Z, bus.Zero, bus.Overflow, bus.Negative};
    exp = {32'h5, 3'b000};
    n_cmp++;
    if (obs !== exp) begin
      n_err++; $display("FAIL midreset_resume: got %h expected %h", obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.A = '0; bus.B = '0; bus.ALUFun = '0; bus.Sign = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_midreset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within the time limit");
    $fatal(1, "timeout");
  end

endmodule
